// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding scoreboard for an in-order pipeline: tracks in-flight writers over
// STAGES post-issue slots, raises load-use stalls and registers per-operand EX forward selects.
module pipe_hazard_scoreboard #(
  parameter  int unsigned STAGES    = 3,
  parameter  int unsigned NSRC      = 2,
  parameter  int unsigned AW        = 5,
  parameter  int unsigned LOAD_SLOT = 2,
  parameter  int unsigned CW        = 32,
  localparam int unsigned SW        = (STAGES > 2) ? $clog2(STAGES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [NSRC*AW-1:0] id_rs,
  input  logic [NSRC-1:0]    id_rs_used,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               flush,
  output logic               stall,
  output logic [NSRC*SW-1:0] ex_fw_sel,
  output logic [STAGES-1:0]  slot_valid,
  output logic [CW-1:0]      stall_cnt
);

  if (STAGES < 2 || LOAD_SLOT < 1 || LOAD_SLOT > STAGES - 1) begin : g_param_err
    $error("pipe_hazard_scoreboard: need STAGES>=2 and 1<=LOAD_SLOT<=STAGES-1");
  end

  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  wr_q;
  logic [STAGES-1:0]  ld_q;
  logic [AW-1:0]      rd_q [STAGES];
  logic [NSRC*SW-1:0] fw_sel_q;
  logic [NSRC*SW-1:0] fw_sel_d;
  logic [CW-1:0]      stall_cnt_q;
  logic [NSRC-1:0]    stall_req;
  logic               issue;

  // Per operand: youngest matching writer decides forward select or load-use stall.
  always_comb begin : hazard_comb
    logic [AW-1:0] rs;
    logic          found;
    logic          hit_ld;
    int unsigned   hit;
    stall_req = '0;
    fw_sel_d  = '0;
    for (int i = 0; i < NSRC; i++) begin
      rs     = id_rs[i*AW +: AW];
      found  = 1'b0;
      hit_ld = 1'b0;
      hit    = 0;
      if (id_valid && id_rs_used[i] && rs != '0) begin
        for (int k = 0; k < STAGES; k++) begin
          if (!found && valid_q[k] && wr_q[k] && rd_q[k] == rs) begin
            found  = 1'b1;
            hit    = k;
            hit_ld = ld_q[k];
          end
        end
      end
      // A writer in the last slot is already visible through the write-before-read RF.
      if (found && hit != STAGES - 1) begin
        if (hit_ld && (hit + 1) < LOAD_SLOT) begin
          stall_req[i] = 1'b1;
        end else begin
          fw_sel_d[i*SW +: SW] = SW'(hit + 1);
        end
      end
    end
  end

  assign stall = (|stall_req) & ~flush & ~reset;
  assign issue = id_valid & ~stall & ~flush;

  // Slot occupancy, forward selects and the saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      fw_sel_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q  <= {valid_q[STAGES-2:0], issue};
      wr_q     <= {wr_q[STAGES-2:0], issue & id_regwrite & (id_rd != '0)};
      ld_q     <= {ld_q[STAGES-2:0], issue & id_memread};
      fw_sel_q <= issue ? fw_sel_d : '0;
      if (stall && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CW'(1);
      end
    end
  end

  // Destination tags only matter alongside valid/wr, so they carry no reset.
  always_ff @(posedge clk) begin
    rd_q[0] <= id_rd;
    for (int k = 1; k < STAGES; k++) begin
      rd_q[k] <= rd_q[k-1];
    end
  end

  assign ex_fw_sel  = fw_sel_q;
  assign slot_valid = valid_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard: vector table for forwarding/stall/flush cases,
// plus hand-written sequences for counter saturation and mid-stream reset.
module tb_pipe_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;
  logic       stall;
  logic [3:0] ex_fw_sel;
  logic [2:0] slot_valid;
  logic [1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard #(.STAGES(3), .NSRC(2), .AW(5), .LOAD_SLOT(2), .CW(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall), .ex_fw_sel(ex_fw_sel), .slot_valid(slot_valid), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       fl;
    logic       e_stall;
    logic [3:0] e_sel;
    logic [2:0] e_sv;
    logic [1:0] e_cnt;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v, logic [4:0] r0, logic [4:0] r1, logic [1:0] u,
                              logic [4:0] d, logic w, logic l, logic f, logic es,
                              logic [3:0] esel, logic [2:0] esv, logic [1:0] ecnt);
    vec_t t;
    t.valid = v; t.rs0 = r0; t.rs1 = r1; t.used = u; t.rd = d; t.wr = w; t.ld = l; t.fl = f;
    t.e_stall = es; t.e_sel = esel; t.e_sv = esv; t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] u, input logic [4:0] d, input logic w,
                       input logic l, input logic f);
    id_valid = v; id_rs = {r1, r0}; id_rs_used = u; id_rd = d;
    id_regwrite = w; id_memread = l; flush = f;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 0, 2'b00, 5, 1, 0, 0,  0, 4'b0000, 3'b001, 0);
    vecs[1]  = mk(1, 5, 0, 2'b01, 0, 0, 0, 0,  0, 4'b0001, 3'b011, 0);
    vecs[2]  = mk(1, 0, 0, 2'b00, 6, 1, 1, 0,  0, 4'b0000, 3'b111, 0);
    vecs[3]  = mk(1, 0, 6, 2'b10, 0, 0, 0, 0,  1, 4'b0000, 3'b110, 1);
    vecs[4]  = mk(1, 0, 6, 2'b10, 0, 0, 0, 0,  0, 4'b1000, 3'b101, 1);
    vecs[5]  = mk(1, 0, 0, 2'b00, 7, 1, 0, 0,  0, 4'b0000, 3'b011, 1);
    vecs[6]  = mk(1, 0, 0, 2'b00, 7, 1, 0, 0,  0, 4'b0000, 3'b111, 1);
    vecs[7]  = mk(1, 7, 0, 2'b01, 0, 0, 0, 0,  0, 4'b0001, 3'b111, 1);
    vecs[8]  = mk(1, 7, 0, 2'b01, 0, 0, 0, 0,  0, 4'b0010, 3'b111, 1);
    vecs[9]  = mk(1, 7, 0, 2'b01, 0, 0, 0, 0,  0, 4'b0000, 3'b111, 1);
    vecs[10] = mk(1, 0, 0, 2'b00, 0, 1, 0, 0,  0, 4'b0000, 3'b111, 1);
    vecs[11] = mk(1, 0, 0, 2'b11, 8, 1, 0, 0,  0, 4'b0000, 3'b111, 1);
    vecs[12] = mk(1, 8, 0, 2'b10, 0, 0, 0, 0,  0, 4'b0000, 3'b111, 1);
    vecs[13] = mk(0, 8, 0, 2'b01, 0, 0, 0, 0,  0, 4'b0000, 3'b110, 1);
    vecs[14] = mk(1, 0, 0, 2'b00, 9, 1, 1, 0,  0, 4'b0000, 3'b101, 1);
    vecs[15] = mk(1, 9, 0, 2'b01, 0, 0, 0, 1,  0, 4'b0000, 3'b010, 1);
    vecs[16] = mk(1, 0, 9, 2'b10, 0, 0, 0, 0,  0, 4'b1000, 3'b101, 1);
    vecs[17] = mk(1, 0, 0, 2'b00, 10, 1, 0, 0, 0, 4'b0000, 3'b011, 1);
    vecs[18] = mk(1, 10, 10, 2'b11, 0, 0, 0, 0, 0, 4'b0101, 3'b111, 1);

    reset = 1'b1;
    drive(1, 5, 5, 2'b11, 5, 1, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(stall), 0);
    chk("reset_sel", 32'(ex_fw_sel), 0);
    chk("reset_sv", 32'(slot_valid), 0);
    chk("reset_cnt", 32'(stall_cnt), 0);
    reset = 1'b0;

    for (int n = 0; n < NV; n++) begin
      drive(vecs[n].valid, vecs[n].rs0, vecs[n].rs1, vecs[n].used, vecs[n].rd,
            vecs[n].wr, vecs[n].ld, vecs[n].fl);
      #2;
      chk($sformatf("v%0d_stall", n), 32'(stall), 32'(vecs[n].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_sel", n), 32'(ex_fw_sel), 32'(vecs[n].e_sel));
      chk($sformatf("v%0d_sv", n), 32'(slot_valid), 32'(vecs[n].e_sv));
      chk($sformatf("v%0d_cnt", n), 32'(stall_cnt), 32'(vecs[n].e_cnt));
    end

    // Chain of loads each consuming the previous one: one stall per link, counter saturates.
    drive(1, 0, 0, 2'b00, 11, 1, 1, 0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 5; n++) begin
      drive(1, 5'(11 + n), 0, 2'b01, 5'(12 + n), 1, 1, 0);
      #2;
      chk($sformatf("sat%0d_stall", n), 32'(stall), 1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_cnt", n), 32'(stall_cnt), (n == 0) ? 2 : 3);
      #1;
      chk($sformatf("sat%0d_retry_stall", n), 32'(stall), 0);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_retry_sel", n), 32'(ex_fw_sel), 32'b0010);
    end

    // Mid-stream reset while a load-use stall is pending.
    drive(1, 16, 0, 2'b01, 0, 0, 0, 0);
    #2;
    chk("pre_reset_stall", 32'(stall), 1);
    reset = 1'b1;
    #1;
    chk("in_reset_stall", 32'(stall), 0);
    @(posedge clk);
    #1;
    chk("mid_reset_sv", 32'(slot_valid), 0);
    chk("mid_reset_sel", 32'(ex_fw_sel), 0);
    chk("mid_reset_cnt", 32'(stall_cnt), 0);
    reset = 1'b0;
    #1;
    chk("post_reset_stall", 32'(stall), 0);
    @(posedge clk);
    #1;
    chk("post_reset_sel", 32'(ex_fw_sel), 0);
    chk("post_reset_sv", 32'(slot_valid), 32'b001);
    chk("post_reset_cnt", 32'(stall_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
